// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one add/sub/shift step per clock, registered signed product.
// Optional macro ZERO_BYPASS_EN: a zero operand skips the iteration and completes after one cycle.
`timescale 1ns/1ps
module booth_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    // Handshake: start is sampled only in IDLE; done is a one-cycle pulse with product
    // already valid, and product holds until the next done.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [WIDTH:0]      a, a_next;
    logic [WIDTH:0]      q, q_next;
    logic [WIDTH:0]      m, m_next;
    logic [WIDTH:0]      sum;
    logic [CW-1:0]       cnt, cnt_next;
    logic [2*WIDTH-1:0]  product_next;
    logic                zero_op;

`ifdef ZERO_BYPASS_EN
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a       <= '0;
            q       <= '0;
            m       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state   <= state_next;
            a       <= a_next;
            q       <= q_next;
            m       <= m_next;
            cnt     <= cnt_next;
            product <= product_next;
        end
    end

    always_comb begin
        state_next   = state;
        a_next       = a;
        q_next       = q;
        m_next       = m;
        cnt_next     = cnt;
        product_next = product;
        sum          = a;
        unique case (state)
            IDLE: begin
                if (start) begin
                    m_next   = {multiplicand[WIDTH-1], multiplicand};
                    a_next   = '0;
                    q_next   = {multiplier, 1'b0};
                    cnt_next = '0;
                    if (zero_op) begin
                        product_next = '0;
                        state_next   = DONE;
                    end else begin
                        state_next   = RUN;
                    end
                end
            end
            RUN: begin
                case (q[1:0])
                    2'b01:   sum = a + m;
                    2'b10:   sum = a - m;
                    default: sum = a;
                endcase
                // Arithmetic shift of {sum, q}: sum LSB falls into q MSB, q LSB is dropped.
                a_next   = {sum[WIDTH], sum[WIDTH:1]};
                q_next   = {sum[0], q[WIDTH:1]};
                cnt_next = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    product_next = {a_next[WIDTH-1:0], q_next[WIDTH:1]};
                    state_next   = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
